// File: rtl/param_snn_core.sv
// param_snn_core: rate-coded sensor encoder, programmable synapse matrix and
// leaky integrate-and-fire output neurons with a refractory period.
// Pipeline: encoder -> synapse sum -> neuron, each stage registered and
// advanced only on en (timestep strobe). Weights are written while en=0.
module param_snn_core #(
  parameter int unsigned INPUTNUM = 4,
  parameter int unsigned EXCNUM   = 2,
  parameter int unsigned SW       = 12,
  parameter int unsigned WW       = 8,
  parameter int unsigned VW       = 16,
  parameter int unsigned LEAK_SH  = 3,
  parameter int unsigned REFRAC   = 4,
  localparam int unsigned NW      = INPUTNUM * EXCNUM,
  localparam int unsigned AW      = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [INPUTNUM*SW-1:0]     Sensor_input,
  input  logic signed [VW-1:0]       exc_thr,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [AW-1:0]              w_addr,
  input  logic signed [WW-1:0]       w_data,
  output logic [EXCNUM-1:0]          Output_spike
);

  // Synapse sum width: headroom for INPUTNUM sign-extended weights.
  localparam int unsigned CW = VW + $clog2(INPUTNUM);
  // Neuron arithmetic width: room for V - leak + cur without overflow.
  localparam int unsigned TW = CW + 2;

  localparam logic [AW:0]            NW_LIM    = NW[AW:0];
  localparam logic [3:0]             REFRAC_RC = REFRAC[3:0];
  localparam logic signed [TW-1:0]   VMAX_T    = {{(TW-VW+1){1'b0}}, {(VW-1){1'b1}}};
  localparam logic signed [VW-1:0]   VMAX_V    = {1'b0, {(VW-1){1'b1}}};

  // ---------------------------------------------------------------------
  // Encoder state
  // ---------------------------------------------------------------------
  logic [SW:0]          acc     [INPUTNUM];
  logic [SW+1:0]        enc_sum [INPUTNUM];
  logic [INPUTNUM-1:0]  pre;

  // ---------------------------------------------------------------------
  // Weight memory, synapse and neuron state
  // ---------------------------------------------------------------------
  logic signed [WW-1:0] w       [NW];
  logic                 w_fire;

  logic signed [CW-1:0] syn_sum [EXCNUM];
  logic signed [CW-1:0] cur     [EXCNUM];

  logic signed [VW-1:0] v       [EXCNUM];
  logic [3:0]           rc      [EXCNUM];
  logic signed [TW-1:0] nt_full [EXCNUM];
  logic signed [VW-1:0] nt_sat  [EXCNUM];
  logic [EXCNUM-1:0]    nt_fire;

  // Per-channel accumulate: sum of residue and new sample.
  always_comb begin
    for (int unsigned i = 0; i < INPUTNUM; i++) begin
      enc_sum[i] = {1'b0, acc[i]} + {2'b00, Sensor_input[i*SW +: SW]};
    end
  end

  // Encoder registers: emit a pre-spike and keep the residue on overflow past 2^SW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      for (int unsigned i = 0; i < INPUTNUM; i++) begin
        acc[i] <= '0;
      end
    end else if (en) begin
      for (int unsigned i = 0; i < INPUTNUM; i++) begin
        if (enc_sum[i][SW+1:SW] != 2'b00) begin
          pre[i] <= 1'b1;
          // enc_sum < 2^(SW+1), so subtracting 2^SW just clears bit SW.
          acc[i] <= {1'b0, enc_sum[i][SW-1:0]};
        end else begin
          pre[i] <= 1'b0;
          acc[i] <= enc_sum[i][SW:0];
        end
      end
    end
  end

  // Weight port handshake: writes only accepted between timesteps, out-of-range dropped.
  always_comb begin
    w_ready = ~en;
    w_fire  = w_valid && w_ready && ({1'b0, w_addr} < NW_LIM);
  end

  // Weight memory registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NW; k++) begin
        w[k] <= '0;
      end
    end else if (w_fire) begin
      w[w_addr] <= w_data;
    end
  end

  // Synapse sum: add sign-extended weights of every active pre-spike.
  always_comb begin
    for (int unsigned j = 0; j < EXCNUM; j++) begin
      syn_sum[j] = '0;
      for (int unsigned i = 0; i < INPUTNUM; i++) begin
        if (pre[i]) begin
          syn_sum[j] = syn_sum[j] + CW'(w[i*EXCNUM + j]);
        end
      end
    end
  end

  // Synapse stage register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < EXCNUM; j++) begin
        cur[j] <= '0;
      end
    end else if (en) begin
      for (int unsigned j = 0; j < EXCNUM; j++) begin
        cur[j] <= syn_sum[j];
      end
    end
  end

  // Leaky integration candidate: saturate to VW, clamp at zero, compare to threshold.
  always_comb begin
    for (int unsigned j = 0; j < EXCNUM; j++) begin
      nt_full[j] = TW'(v[j]) - (TW'(v[j]) >>> LEAK_SH) + TW'(cur[j]);
      if (nt_full[j][TW-1]) begin
        nt_sat[j] = '0;
      end else if (nt_full[j] > VMAX_T) begin
        nt_sat[j] = VMAX_V;
      end else begin
        nt_sat[j] = nt_full[j][VW-1:0];
      end
      nt_fire[j] = (nt_sat[j] >= exc_thr);
    end
  end

  // Neuron registers: refractory hold, fire-and-reset, or integrate; spikes last one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Output_spike <= '0;
      for (int unsigned j = 0; j < EXCNUM; j++) begin
        v[j]  <= '0;
        rc[j] <= '0;
      end
    end else begin
      Output_spike <= '0;
      if (en) begin
        for (int unsigned j = 0; j < EXCNUM; j++) begin
          if (rc[j] != 4'd0) begin
            rc[j] <= rc[j] - 4'd1;
            v[j]  <= '0;
          end else if (nt_fire[j]) begin
            Output_spike[j] <= 1'b1;
            v[j]            <= '0;
            rc[j]           <= REFRAC_RC;
          end else begin
            v[j] <= nt_sat[j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_param_snn_core.sv
// Directed bench for param_snn_core: two instances (REFRAC=0 and REFRAC=4)
// share all inputs; spike trains are compared against hand-derived masks
// (bit k-1 of a mask = expected spike right after the k-th en edge).
module tb_param_snn_core;
  localparam int unsigned INPUTNUM = 4;
  localparam int unsigned EXCNUM   = 2;
  localparam int unsigned SW       = 12;
  localparam int unsigned WW       = 8;
  localparam int unsigned VW       = 16;
  localparam int unsigned AW       = $clog2(INPUTNUM*EXCNUM);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic [INPUTNUM*SW-1:0]   sensor;
  logic signed [VW-1:0]     thr;
  logic                     w_valid;
  logic [AW-1:0]            w_addr;
  logic signed [WW-1:0]     w_data;
  logic                     w_ready0, w_ready4;
  logic [EXCNUM-1:0]        spk0, spk4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_snn_core #(.INPUTNUM(INPUTNUM), .EXCNUM(EXCNUM), .SW(SW), .WW(WW), .VW(VW),
                   .LEAK_SH(3), .REFRAC(0)) dut (
    .clk(clk), .rst(rst), .en(en), .Sensor_input(sensor), .exc_thr(thr),
    .w_valid(w_valid), .w_ready(w_ready0), .w_addr(w_addr), .w_data(w_data),
    .Output_spike(spk0)
  );

  param_snn_core #(.INPUTNUM(INPUTNUM), .EXCNUM(EXCNUM), .SW(SW), .WW(WW), .VW(VW),
                   .LEAK_SH(3), .REFRAC(4)) dut_r (
    .clk(clk), .rst(rst), .en(en), .Sensor_input(sensor), .exc_thr(thr),
    .w_valid(w_valid), .w_ready(w_ready4), .w_addr(w_addr), .w_data(w_data),
    .Output_spike(spk4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b0;
    w_valid = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    sensor  = '0;
    thr     = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_w(input logic [AW-1:0] a, input logic signed [WW-1:0] d);
    en      = 1'b0;
    w_valid = 1'b1;
    w_addr  = a;
    w_data  = d;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [SW-1:0] val);
    sensor[ch*SW +: SW] = val;
  endtask

  // Run n en cycles; neuron 1 has no weights in these tests so it stays silent.
  task automatic run_seq(input string tag, input int n, input logic [31:0] m0, input logic [31:0] m4);
    en = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("%s_r0_e%0d", tag, k), {30'd0, spk0}, {31'd0, m0[k-1]});
      check($sformatf("%s_r4_e%0d", tag, k), {30'd0, spk4}, {31'd0, m4[k-1]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and combinational w_ready during reset
    rst = 1'b1; en = 1'b0; w_valid = 1'b0; w_addr = '0; w_data = '0; sensor = '0; thr = '0;
    #7;
    check("rst_spk0", {30'd0, spk0}, 32'd0);
    check("rst_spk4", {30'd0, spk4}, 32'd0);
    check("rst_wready_en0", {31'd0, w_ready0}, 32'd1);
    en = 1'b1; #1;
    check("rst_wready_en1", {31'd0, w_ready0}, 32'd0);
    en = 1'b0;
    tick();
    rst = 1'b0;

    // Encoder rate 2048: pre alternates 0,1,... -> spikes every other step from E4
    do_reset();
    write_w(0, 8'sd127);
    thr = 16'sd1; set_ch(0, 12'd2048);
    run_seq("enc2048", 10, 32'h2A8, 32'h208);

    // Encoder rate 0: never fires
    do_reset();
    write_w(0, 8'sd127);
    thr = 16'sd1; set_ch(0, 12'd0);
    run_seq("enc0", 8, 32'h0, 32'h0);

    // Encoder rate 4095: fires every step from E2, spikes from E4
    do_reset();
    write_w(0, 8'sd127);
    thr = 16'sd1; set_ch(0, 12'd4095);
    run_seq("enc4095", 10, 32'h3F8, 32'h108);
    en = 1'b0;
    tick();
    check("en0_spk0", {30'd0, spk0}, 32'd0);
    check("en0_spk4", {30'd0, spk4}, 32'd0);
    en = 1'b1;
    tick();
    check("resume_spk0", {30'd0, spk0}, 32'd1);
    check("resume_spk4", {30'd0, spk4}, 32'd0);

    // Integration 100,188,265 -> spike; REFRAC=4 holds 4 extra steps
    do_reset();
    write_w(0, 8'sd100);
    thr = 16'sd250; set_ch(0, 12'd4095);
    run_seq("integ", 14, 32'h920, 32'h1020);

    // Inhibition clamps at 0, then integration starts exactly from 0
    do_reset();
    write_w(2, -8'sd59);
    thr = 16'sd1; set_ch(1, 12'd4095);
    run_seq("inhib", 6, 32'h0, 32'h0);
    write_w(0, 8'sd100);
    thr = 16'sd250; set_ch(0, 12'd4095); set_ch(1, 12'd0);
    run_seq("clamp", 6, 32'h20, 32'h20);

    // Saturation scenario: large drive, threshold at VW max, no spike or wrap
    do_reset();
    for (int i = 0; i < 4; i++) write_w(AW'(i*2), 8'sd127);
    thr = 16'sd32767;
    for (int i = 0; i < 4; i++) set_ch(i, 12'd4095);
    run_seq("sat", 8, 32'h0, 32'h0);

    // Write handshake: stalled while en=1, lands when en drops
    do_reset();
    thr = 16'sd1; set_ch(0, 12'd4095);
    en = 1'b1; w_valid = 1'b1; w_addr = '0; w_data = 8'sd127;
    #1;
    check("hs_wready_stall", {31'd0, w_ready0}, 32'd0);
    run_seq("hs_stall", 6, 32'h0, 32'h0);
    en = 1'b0;
    #1;
    check("hs_wready_accept", {31'd0, w_ready0}, 32'd1);
    check("hs_wready4_accept", {31'd0, w_ready4}, 32'd1);
    tick();
    w_valid = 1'b0;
    run_seq("hs_after", 2, 32'h2, 32'h2);

    // Reset mid-run: clears spike asynchronously, drops pending write, wipes weights
    do_reset();
    write_w(0, 8'sd100);
    thr = 16'sd250; set_ch(0, 12'd4095);
    run_seq("mid_pre", 6, 32'h20, 32'h20);
    #2;
    rst = 1'b1;
    #1;
    check("mid_async_spk0", {30'd0, spk0}, 32'd0);
    check("mid_async_spk4", {30'd0, spk4}, 32'd0);
    en = 1'b0; w_valid = 1'b1; w_addr = '0; w_data = 8'sd127;
    #1;
    check("mid_wready_rst", {31'd0, w_ready0}, 32'd1);
    tick();
    w_valid = 1'b0;
    rst = 1'b0;
    thr = 16'sd1;
    run_seq("mid_post", 8, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
